// File: rtl/addsub_pipe_n.sv
// addsub_pipe_n: pipelined add/subtract split into STAGES carry-chained segments with
// valid/ready flow control. Define ADDSUB_SAT_EN to clamp SUM on signed overflow.
module addsub_pipe_n #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             O
);
    localparam int SEG = WIDTH / STAGES;

    logic                         adv;
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic                         o_q, o_d;
    logic                         unused_ok;

    // The whole pipe moves as one; a full output register that is not taken freezes it.
    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] s_in, s_w;
        logic [SEG-1:0]   seg_s;
        logic             c_in;

        if (k == 0) begin : g_head
            // Subtract is A + ~B + 1: B is inverted once here and the carry-in seeds segment 0.
            assign vld_d[k] = in_valid;
            assign a_d[k]   = A;
            assign b_d[k]   = Add_ctrl ? B : ~B;
            assign c_in     = ~Add_ctrl;
            assign s_in     = '0;
        end else begin : g_body
            assign vld_d[k] = vld_q[k-1];
            assign a_d[k]   = a_q[k-1];
            assign b_d[k]   = b_q[k-1];
            assign c_in     = c_q[k-1];
            assign s_in     = s_q[k-1];
        end

        assign {c_d[k], seg_s} = {1'b0, a_d[k][k*SEG +: SEG]}
                               + {1'b0, b_d[k][k*SEG +: SEG]}
                               + {{SEG{1'b0}}, c_in};

        always_comb begin
            s_w               = s_in;
            s_w[k*SEG +: SEG] = seg_s;
        end

        if (k == STAGES-1) begin : g_tail
            logic c_msb;
            // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
            assign c_msb = s_w[WIDTH-1] ^ a_d[k][WIDTH-1] ^ b_d[k][WIDTH-1];
            assign o_d   = c_msb ^ c_d[k];
`ifdef ADDSUB_SAT_EN
            // Overflow needs like-signed operands, so A's sign selects the rail.
            assign s_d[k] = o_d ? {a_d[k][WIDTH-1], {(WIDTH-1){~a_d[k][WIDTH-1]}}} : s_w;
`else
            assign s_d[k] = s_w;
`endif
        end else begin : g_mid
            assign s_d[k] = s_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            o_q   <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            o_q   <= o_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign SUM       = s_q[STAGES-1];
    assign C_out     = c_q[STAGES-1];
    assign O         = o_q;

    // Operands are fully consumed by the last segment; nothing downstream reads them.
    assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};
endmodule

// File: tb/tb_addsub_pipe_n.sv
// Directed bench for addsub_pipe_n (WIDTH=16, STAGES=4): latency, back-to-back,
// backpressure, mid-flight reset and randomised handshakes over a hand-computed vector table.
module tb_addsub_pipe_n;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, Add_ctrl;
    logic         out_valid, out_ready, C_out, O;
    logic [W-1:0] A, B, SUM;

    always #5 clk = ~clk;

    addsub_pipe_n #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Add_ctrl(Add_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .C_out(C_out), .O(O)
    );

    // A, B, Add_ctrl, wrapped SUM, saturated SUM, C_out, O
    localparam logic [15:0] VA   [10] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h1234,
                                         16'h0000, 16'h8000, 16'h00FF, 16'h7FFF, 16'h0003};
    localparam logic [15:0] VB   [10] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321,
                                         16'h0000, 16'h8000, 16'h0F01, 16'hFFFF, 16'h0004};
    localparam logic        VC   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [15:0] VSUM [10] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h5555,
                                         16'h0000, 16'h0000, 16'h1000, 16'h8000, 16'h0007};
    localparam logic [15:0] VSAT [10] = '{16'h7FFF, 16'h0000, 16'hFFFE, 16'h8000, 16'h5555,
                                         16'h0000, 16'h8000, 16'h1000, 16'h7FFF, 16'h0007};
    localparam logic        VCO  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        VO   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int nres   = 0;
    bit lat_on = 1'b0;
    int exp_q[$];
    int acc_q[$];

    function automatic logic [15:0] exp_sum(input int i);
`ifdef ADDSUB_SAT_EN
        return VSAT[i];
`else
        return VSUM[i];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One cycle, called at a falling edge: drive, settle, score both handshakes.
    task automatic cyc(input bit iv, input int idx, input bit ordy, output bit acc);
        int e, t;
        in_valid  = iv;
        A         = VA[idx];
        B         = VB[idx];
        Add_ctrl  = VC[idx];
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                nres++;
                chk("sum", 32'(SUM), 32'(exp_sum(e)));
                chk("c_out", 32'(C_out), 32'(VCO[e]));
                chk("ovf", 32'(O), 32'(VO[e]));
                if (lat_on) chk("latency", 32'(cyc_n - t), 32'd4);
            end
        end
        if (acc) begin
            exp_q.push_back(idx);
            acc_q.push_back(cyc_n);
        end
        cyc_n++;
    endtask

    task automatic drain(input string tag);
        bit a;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            @(negedge clk);
            cyc(1'b0, 0, 1'b1, a);
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          ptr, stall, n0;
        bit          seen;
        logic [15:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Add_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst sum", 32'(SUM), 32'd0);
        chk("rst c_out", 32'(C_out), 32'd0);
        chk("rst ovf", 32'(O), 32'd0);
        rst_n = 1'b1;

        // single op, exact latency
        lat_on = 1'b1;
        @(negedge clk); cyc(1'b1, 0, 1'b1, acc);
        chk("t1 accept", 32'(acc), 32'd1);
        drain("t1 drain");

        // back-to-back
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); cyc(1'b1, i, 1'b1, acc);
            chk("t2 accept", 32'(acc), 32'd1);
        end
        drain("t2 drain");
        @(negedge clk);
        chk("t2 idle", 32'(out_valid), 32'd0);

        // backpressure: 3 stalled cycles after the first result
        lat_on = 1'b0; ptr = 4; stall = 0; seen = 1'b0; held = '0; n0 = nres;
        for (int g = 0; g < 100 && (ptr < 10 || exp_q.size() > 0); g++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1; stall = 3; held = SUM;
            end else if (stall > 0) begin
                chk("t3 hold_sum", 32'(SUM), 32'(held));
                chk("t3 hold_vld", 32'(out_valid), 32'd1);
            end
            cyc(ptr < 10, (ptr < 10) ? ptr : 0, stall == 0, acc);
            if (stall > 0) begin
                chk("t3 stall_in_ready", 32'(in_ready), 32'd0);
                stall--;
            end
            if (acc) ptr++;
        end
        chk("t3 results", 32'(nres - n0), 32'd6);
        @(negedge clk);
        chk("t3 idle", 32'(out_valid), 32'd0);

        // reset with work in flight
        lat_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cyc(1'b1, i, 1'b1, acc);
        end
        @(negedge clk); cyc(1'b0, 0, 1'b1, acc);
        @(negedge clk);
        chk("t4 pre_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4 rst_vld", 32'(out_valid), 32'd0);
        chk("t4 rst_sum", 32'(SUM), 32'd0);
        chk("t4 rst_c_out", 32'(C_out), 32'd0);
        chk("t4 rst_ovf", 32'(O), 32'd0);
        chk("t4 rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        acc_q.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4 no_stale", 32'(out_valid), 32'd0);
            cyc(1'b0, 0, 1'b1, acc);
        end
        @(negedge clk); cyc(1'b1, 4, 1'b1, acc);
        chk("t4 accept", 32'(acc), 32'd1);
        drain("t4 drain");

        // randomised valid/ready over the table
        lat_on = 1'b0; n0 = nres;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 9)), $urandom_range(0, 3) != 0, acc);
        end
        drain("t5 drain");
        chk("t5 some_results", 32'(nres - n0 > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
